// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: funct3 access encodings,
// the access FSM state type and the store byte-strobe patterns.
package mem_pkg;

    // funct3 encodings for load/store size and sign
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access FSM: idle, request pending grant, waiting for read data
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Byte-strobe patterns for lane 0; shifted by the byte offset
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/half
// from the read word and sign- or zero-extends it.
// Ports: i_rdata (read word), i_a (byte offset), i_funct3 (size/sign),
//        o_data (32-bit writeback value).
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_a,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_a)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32I pipeline: issues data-memory accesses over a
// req/gnt/rvalid handshake, builds store strobes/lane data, formats
// load data, stalls while an access is outstanding and registers the
// MEM/WB result.
// Ports: clk, rst (async, active-high); mem_* EXE/MEM register inputs;
//        dm_* data-memory request/response; mem_stall, mem_fwd_data,
//        mem_misalign; wb_regwrite, wb_rd_addr, wb_data (registered).
// Build option: define MEM_MISALIGN_CHK_EN to block misaligned
//        half/word accesses and flag them on mem_misalign.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rdsrc,
    input  logic              mem_memread,
    input  logic              mem_memwrite,
    input  logic              mem_memtoreg,
    input  logic              mem_regwrite,
    input  logic [31:0]       mem_pc_to_reg,
    input  logic [31:0]       mem_alu_out,
    input  logic [31:0]       mem_rs2_data,
    input  logic [4:0]        mem_rd_addr,
    input  logic [2:0]        mem_funct3,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              mem_stall,
    output logic [31:0]       mem_fwd_data,
    output logic              mem_misalign,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data
);

    state_t      r_state;
    state_t      w_next;
    logic        w_mem;
    logic        w_store;
    logic        w_mis;
    logic        w_issue;
    logic        w_req;
    logic        w_done;
    logic        w_load_done;
    logic [1:0]  w_a;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_fwd;
    logic [31:0] w_ldata;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_data;

    // A simultaneous read+write is handled as a store
    assign w_mem   = mem_memread | mem_memwrite;
    assign w_store = mem_memwrite;
    assign w_a     = mem_alu_out[1:0];
    assign w_fwd   = mem_rdsrc ? mem_pc_to_reg : mem_alu_out;

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        w_mis = 1'b0;
        if (w_mem) begin
            case (mem_funct3)
                F3_H, F3_HU: w_mis = w_a[0];
                F3_W:        w_mis = |w_a;
                default:     w_mis = 1'b0;
            endcase
        end
    end
`else
    assign w_mis = 1'b0;
`endif

    assign w_issue = w_mem & ~w_mis;

    // Request is combinational so an access can be granted in the
    // first cycle; rst gates it so the bus is released immediately.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_IDLE: w_req = w_issue;
            ST_REQ:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        w_req = w_req & ~rst;
    end

    assign w_load_done = (r_state == ST_WAIT) & dm_rvalid;
    assign w_done      = (w_store & w_req & dm_gnt) | w_load_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    if (!dm_gnt)     w_next = ST_REQ;
                    else if (!w_store) w_next = ST_WAIT;
                end
            end
            ST_REQ: begin
                if (dm_gnt) w_next = w_store ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (dm_rvalid) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Store lane replication and byte enables
    always_comb begin
        w_strb  = STRB_NONE;
        w_wdata = mem_rs2_data;
        case (mem_funct3)
            F3_B: begin
                w_strb  = STRB_B << w_a;
                w_wdata = {4{mem_rs2_data[7:0]}};
            end
            F3_H: begin
                w_strb  = STRB_H << {w_a[1], 1'b0};
                w_wdata = {2{mem_rs2_data[15:0]}};
            end
            F3_W: begin
                w_strb  = STRB_W;
                w_wdata = mem_rs2_data;
            end
            default: begin
                w_strb  = STRB_NONE;
                w_wdata = mem_rs2_data;
            end
        endcase
    end

    assign dm_req   = w_req;
    assign dm_we    = w_req & w_store;
    assign dm_addr  = w_req ? {mem_alu_out[ADDR_W-1:2], 2'b00} : '0;
    assign dm_wstrb = (w_req & w_store) ? w_strb : STRB_NONE;
    assign dm_wdata = (w_req & w_store) ? w_wdata : 32'd0;

    assign mem_stall    = w_issue & ~w_done & ~rst;
    assign mem_fwd_data = rst ? 32'd0 : w_fwd;
    assign mem_misalign = w_mis & ~rst;

    load_formatter u_fmt (
        .i_rdata  (dm_rdata),
        .i_a      (w_a),
        .i_funct3 (mem_funct3),
        .o_data   (w_ldata)
    );

    // While stalled, WB sees a bubble so the instruction writes once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_regwrite <= 1'b0;
            r_wb_rd_addr  <= 5'd0;
            r_wb_data     <= 32'd0;
        end else if (mem_stall) begin
            r_wb_regwrite <= 1'b0;
            r_wb_rd_addr  <= 5'd0;
            r_wb_data     <= 32'd0;
        end else begin
            r_wb_regwrite <= mem_regwrite & ~w_mis;
            r_wb_rd_addr  <= mem_rd_addr;
            r_wb_data     <= (w_load_done & mem_memtoreg) ? w_ldata : w_fwd;
        end
    end

    assign wb_regwrite = r_wb_regwrite;
    assign wb_rd_addr  = r_wb_rd_addr;
    assign wb_data     = r_wb_data;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the 5-stage RV32I pipeline; consumes the EXE/MEM pipeline register outputs.
- Issues load/store requests to data memory over a req/gnt/rvalid handshake.
- Formats load data (sign/zero extension) and generates store byte strobes.
- Stalls the pipeline while an access is outstanding; registers the MEM/WB result.

Parameters:
- ADDR_W, 32, width of dm_addr; upper bits of the ALU result are truncated.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_rdsrc  in  1  1: rd value is pc_to_reg (JAL/JALR); 0: ALU result
- mem_memread  in  1  load in MEM
- mem_memwrite  in  1  store in MEM
- mem_memtoreg  in  1  writeback selects load data
- mem_regwrite  in  1  instruction writes rd
- mem_pc_to_reg  in  32  PC+4 for link
- mem_alu_out  in  32  effective address / ALU result
- mem_rs2_data  in  32  store data
- mem_rd_addr  in  5  destination register
- mem_funct3  in  3  access size/sign
- dm_req  out  1  request valid
- dm_we  out  1  1 = store
- dm_addr  out  ADDR_W  word-aligned address {alu_out[ADDR_W-1:2],2'b00}
- dm_wstrb  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_gnt  in  1  request accepted
- dm_rvalid  in  1  read data valid
- dm_rdata  in  32  read word
- mem_stall  out  1  freeze PC, IF/ID, ID/EXE, EXE/MEM (drives the EXE/MEM write enable low)
- mem_fwd_data  out  32  combinational rd value for EX forwarding (rdsrc ? pc_to_reg : alu_out)
- mem_misalign  out  1  misaligned-access pulse (optional feature)
- wb_regwrite  out  1  registered
- wb_rd_addr  out  5  registered
- wb_data  out  32  registered writeback value

Behaviour:
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if memread or memwrite, drive dm_req=1 combinationally.
    - gnt && store: store done, stay IDLE.
    - gnt && load: go to WAIT.
    - no gnt: go to REQ.
  - REQ: hold dm_req=1 with all dm_* stable until gnt. Then store → IDLE, load → WAIT.
  - WAIT: dm_req=0. On rvalid, capture formatted data into wb_data and go to IDLE.
- Completion timing:
  - rvalid never arrives in the gnt cycle; minimum load latency is 2 cycles.
  - A store completes in its gnt cycle.
- mem_stall = (memread|memwrite) & ~done_now, where done_now = (store & gnt) | (state==WAIT & rvalid).
  - In the completion cycle mem_stall is low, so EXE/MEM advances on the same edge.
  - The access is issued exactly once.
- While mem_stall=1 the WB register loads a bubble: wb_regwrite=0, wb_rd_addr=0.
- Non-memory instructions: no stall. WB captures regwrite, rd_addr, and wb_data=fwd value every cycle.
- Store lanes (a = alu_out[1:0]):
  - SB (000): wstrb = 0001<<a, wdata = {4{rs2[7:0]}}
  - SH (001): wstrb = 0011<<(a[1]*2), wdata = {2{rs2[15:0]}}
  - SW (010): wstrb = 1111, wdata = rs2
  - Other funct3: wstrb = 0000.
- Load format:
  - LB/LBU select byte a; LH/LHU select half a[1]; LW takes the full word.
  - 000/001 sign-extend; 100/101 zero-extend; other funct3 returns the full word.
- wb_data for a completed load = formatted data (memtoreg=1).
- Reset values: all outputs 0; FSM to IDLE.
  - Reset mid-access aborts it; dm_req drops asynchronously and no WB write occurs.
- Simultaneous memread & memwrite is illegal; treat it as a store.
- dm_we = memwrite; valid only while dm_req=1. Otherwise dm_* are 0.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Defined:
  - Misaligned LH/LHU/SH (a[0]=1) or LW/SW (a!=0) are not issued (dm_req=0) and cause no stall.
  - mem_misalign pulses 1 for one cycle; that instruction's WB write is suppressed (wb_regwrite=0).
- Undefined:
  - mem_misalign is tied 0; low address bits are ignored beyond the lane rules above.

Decomposition:
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, strobe constants.
- One sub-module: load_formatter, combinational (rdata, a, funct3 → 32-bit result).
- Strobe/wdata generation and the FSM stay in the top module.

Test Plan:
- SW addr 0x100, rs2=0xDEADBEEF, gnt in cycle 0 → one dm_req cycle, wstrb=1111, mem_stall=0, wb_regwrite=0.
- LB addr 0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80FF0000 → stall for 3 cycles, wb_data=0xFFFFFF80, wb_rd_addr correct.
- LHU addr 0x102, rdata=0x8001_1234 → wb_data=0x00008001; SH addr 0x102, rs2=0xABCD → wstrb=1100, wdata=0xABCDABCD.
- Back-to-back load then ALU op (rdsrc=0, alu_out=7) → load writes once; the next cycle WB shows 7 with no extra stall.
- rst asserted while in WAIT → dm_req=0, FSM IDLE, all wb_* 0; a later rvalid is ignored.
- With MEM_MISALIGN_CHK_EN, LW addr 0x101 → dm_req=0, mem_misalign=1 for one cycle, wb_regwrite=0.
